instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with an output register and a one-entry skid buffer.
// Optional performance counters are compiled in when INSTR_FETCH_PERF_CNT_EN is defined.

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscallFlag_i,
  input  logic        branchFlush_i,
  input  logic [31:0] branchTarget_i,
  input  logic        loadStall_i,
  output logic        imemReq_o,
  output logic [31:0] imemAddr_o,
  input  logic [31:0] imemRdata_i,
  input  logic        imemValid_i,
  output logic [31:0] pcOut_o,
  output logic [31:0] instrIn_o
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetchCount_o,
  output logic [31:0] stallCount_o
`endif
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] out_pc_r;
  logic [31:0] out_instr_r;
  logic        out_full_r;
  logic [31:0] skid_pc_r;
  logic [31:0] skid_instr_r;
  logic        skid_full_r;

  logic        req_fire_s;
  logic        deliver_s;
  logic        consume_s;
  logic        drain_next_s;

  // Request/delivery qualifiers; syscall and flush suppress both so nothing new is started or accepted
  always_comb begin
    req_fire_s   = (state_r == REQ) && !skid_full_r && !syscallFlag_i && !branchFlush_i;
    deliver_s    = (state_r == WAIT) && imemValid_i && !syscallFlag_i && !branchFlush_i;
    consume_s    = out_full_r && !loadStall_i;
    drain_next_s = ((state_r == WAIT) || (state_r == DRAIN)) && !imemValid_i;
  end

  assign imemReq_o  = req_fire_s && !rst;
  assign imemAddr_o = pc_r;
  assign pcOut_o    = out_pc_r;
  assign instrIn_o  = out_instr_r;

  // Fetch FSM with pc, output register and skid register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= REQ;
      pc_r         <= RESET_PC;
      out_pc_r     <= 32'd0;
      out_instr_r  <= 32'd0;
      out_full_r   <= 1'b0;
      skid_pc_r    <= 32'd0;
      skid_instr_r <= 32'd0;
      skid_full_r  <= 1'b0;
    end else if (state_r == HALT) begin
      state_r <= HALT;
    end else if (syscallFlag_i) begin
      state_r      <= HALT;
      out_pc_r     <= 32'd0;
      out_instr_r  <= 32'd0;
      out_full_r   <= 1'b0;
      skid_pc_r    <= 32'd0;
      skid_instr_r <= 32'd0;
      skid_full_r  <= 1'b0;
    end else if (branchFlush_i) begin
      // A response still in flight must be swallowed before the new target is requested
      state_r      <= drain_next_s ? DRAIN : REQ;
      pc_r         <= branchTarget_i;
      out_pc_r     <= 32'd0;
      out_instr_r  <= 32'd0;
      out_full_r   <= 1'b0;
      skid_pc_r    <= 32'd0;
      skid_instr_r <= 32'd0;
      skid_full_r  <= 1'b0;
    end else begin
      case (state_r)
        REQ: begin
          if (req_fire_s) state_r <= WAIT;
        end
        WAIT: begin
          if (imemValid_i) begin
            pc_r    <= pc_r + 32'd4;
            state_r <= REQ;
          end
        end
        DRAIN: begin
          if (imemValid_i) state_r <= REQ;
        end
        default: state_r <= REQ;
      endcase

      if (consume_s) begin
        if (skid_full_r) begin
          out_pc_r     <= skid_pc_r;
          out_instr_r  <= skid_instr_r;
          out_full_r   <= 1'b1;
          skid_full_r  <= deliver_s;
          skid_pc_r    <= deliver_s ? pc_r : 32'd0;
          skid_instr_r <= deliver_s ? imemRdata_i : 32'd0;
        end else if (deliver_s) begin
          out_pc_r    <= pc_r;
          out_instr_r <= imemRdata_i;
          out_full_r  <= 1'b1;
        end else begin
          out_pc_r    <= 32'd0;
          out_instr_r <= 32'd0;
          out_full_r  <= 1'b0;
        end
      end else if (deliver_s) begin
        if (out_full_r) begin
          skid_pc_r    <= pc_r;
          skid_instr_r <= imemRdata_i;
          skid_full_r  <= 1'b1;
        end else begin
          out_pc_r    <= pc_r;
          out_instr_r <= imemRdata_i;
          out_full_r  <= 1'b1;
        end
      end
    end
  end

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;

  // Accepted deliveries and stalled-while-full cycles, both wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (deliver_s) fetch_cnt_r <= fetch_cnt_r + 32'd1;
      if ((state_r != HALT) && !syscallFlag_i && !branchFlush_i && loadStall_i && out_full_r)
        stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign fetchCount_o = fetch_cnt_r;
  assign stallCount_o = stall_cnt_r;
`endif

endmodule
